// File: rtl/inv_pkg.sv
// inv_pipe shared helpers: stage count, occupancy width
// and the per-stage {valid, data} record.
`define INV_STAGE_T(WD) struct packed {logic v; logic [(WD)-1:0] d;}

package inv_pkg;

  function automatic int ceil_div(input int n, input int k);
    return (n + k - 1) / k;
  endfunction

  function automatic int occ_width(input int n, input int k);
    return $clog2(ceil_div(n, k) + 1);
  endfunction

  function automatic int last_depth(input int n, input int k);
    return n - (ceil_div(n, k) - 1) * k;
  endfunction

endpackage

// File: rtl/inv_seg.sv
// inv_seg: W-bit wide, M-deep combinational inverter chain.
// Library cells in synthesis so the chain is not collapsed.
module inv_seg #(
  parameter int W = 8,
  parameter int M = 2
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  logic [W-1:0] c [M+1];

  assign c[0] = a;

  for (genvar i = 0; i < M; i++) begin : g_inv
`ifdef SYNTHESIS
    for (genvar b = 0; b < W; b++) begin : g_bit
      inv_cell u_cell (
        .a (c[i][b]),
        .y (c[i+1][b])
      );
    end
`else
    assign c[i+1] = ~c[i];
`endif
  end

  assign y = c[M];

endmodule

// File: rtl/inv_pipe.sv
// inv_pipe: N inverters per bit in segments of K, one register
// per segment, valid/ready at both ends, flush and occupancy.
module inv_pipe
  import inv_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 6,
  parameter int K = 2,
  localparam int S = ceil_div(N, K),
  localparam int OW = occ_width(N, K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  input  logic          flush,
  output logic [OW-1:0] occupancy
);

  localparam int ML = last_depth(N, K);

  typedef `INV_STAGE_T(W) stage_t;

  stage_t       st    [S];
  logic [W-1:0] seg_a [S];
  logic [W-1:0] seg_y [S];
  logic [S:0]   r;
  logic         take;

  assign r[S] = out_ready;

  for (genvar j = 0; j < S; j++) begin : g_stage
    if (j == 0) begin : g_first
      assign seg_a[j] = in_data;
    end else begin : g_next
      assign seg_a[j] = st[j-1].d;
    end

    inv_seg #(
      .W (W),
      .M ((j == S - 1) ? ML : K)
    ) u_seg (
      .a (seg_a[j]),
      .y (seg_y[j])
    );

    assign r[j] = ~st[j].v | r[j+1];
  end

  assign in_ready = r[0] & ~flush;
  assign take     = in_valid & in_ready;

  // flush clears only valid bits; data fields keep their contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < S; j++) st[j] <= '0;
    end else if (flush) begin
      for (int j = 0; j < S; j++) st[j].v <= 1'b0;
    end else begin
      if (r[0]) st[0] <= '{v: take, d: seg_y[0]};
      for (int j = 1; j < S; j++) begin
        if (r[j]) st[j] <= '{v: st[j-1].v, d: seg_y[j]};
      end
    end
  end

  assign out_valid = st[S-1].v;
  assign out_data  = st[S-1].d;

  always_comb begin
    occupancy = '0;
    for (int j = 0; j < S; j++) begin
      occupancy = occupancy + OW'(st[j].v);
    end
  end

endmodule

// File: tb/tb_inv_pipe.sv
// tb_inv_pipe: scenario tasks plus a queue-based random check
// of inv_pipe, and a parameter sweep on extra instances.
module tb_inv_pipe;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       flush = 1'b0;
  logic [1:0] occupancy;

  logic       sw_valid = 1'b0;
  logic [7:0] sw_data = '0;
  logic       sw_ready = 1'b1;
  logic       sw_flush = 1'b0;
  logic       sir [5];
  logic       sov [5];
  logic [7:0] sod [5];
  logic       e_od;
  logic [1:0] occ_a;
  logic [2:0] occ_b;
  logic       occ_c;
  logic       occ_d;
  logic [1:0] occ_e;

  int total = 0;
  int bad = 0;
  logic [7:0] q [$];

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  inv_pipe #(.W(8), .N(6), .K(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
  );

  inv_pipe #(.W(8), .N(5), .K(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sir[0]),
    .in_data(sw_data),
    .out_valid(sov[0]), .out_ready(sw_ready),
    .out_data(sod[0]),
    .flush(sw_flush), .occupancy(occ_a)
  );

  inv_pipe #(.W(8), .N(6), .K(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sir[1]),
    .in_data(sw_data),
    .out_valid(sov[1]), .out_ready(sw_ready),
    .out_data(sod[1]),
    .flush(sw_flush), .occupancy(occ_b)
  );

  inv_pipe #(.W(8), .N(6), .K(6)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sir[2]),
    .in_data(sw_data),
    .out_valid(sov[2]), .out_ready(sw_ready),
    .out_data(sod[2]),
    .flush(sw_flush), .occupancy(occ_c)
  );

  inv_pipe #(.W(8), .N(1), .K(1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sir[3]),
    .in_data(sw_data),
    .out_valid(sov[3]), .out_ready(sw_ready),
    .out_data(sod[3]),
    .flush(sw_flush), .occupancy(occ_d)
  );

  inv_pipe #(.W(1), .N(3), .K(2)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_valid), .in_ready(sir[4]),
    .in_data(sw_data[0]),
    .out_valid(sov[4]), .out_ready(sw_ready),
    .out_data(e_od),
    .flush(sw_flush), .occupancy(occ_e)
  );

  assign sod[4] = {7'b0, e_od};

  function automatic logic [7:0] inv8(input logic [7:0] x, input int n);
    return (n % 2 == 1) ? ~x : x;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clk_en = 1'b0;
    #1;
    total++;
    if (occupancy !== 2'd2) begin
      bad++;
      $display("FAIL reset_preload occ got=%0d want=2", occupancy);
    end
    #2 rst_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        occupancy !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset ov=%b od=%h occ=%0d ir=%b want 0 00 0 1",
               out_valid, out_data, occupancy, in_ready);
    end
    #2 rst_n = 1'b1;
    clk_en = 1'b1;
    out_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_single;
    bit ok;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      total++;
      ok = (c < 2) ? (out_valid === 1'b0)
                   : (out_valid === 1'b1 && out_data === 8'hA5);
      if (!ok) begin
        bad++;
        $display("FAIL single cyc=%0d ov=%b od=%h want ov=%0d od=a5",
                 c, out_valid, out_data, c == 2);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    for (int c = 0; c < 258; c++) begin
      @(negedge clk);
      in_valid = (c < 256); in_data = 8'(c); out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (c >= 2) begin
        w = 8'(c - 2);
        total++;
        if (out_valid !== 1'b1 || out_data !== inv8(w, 6)) begin
          bad++;
          $display("FAIL stream idx=%0d ov=%b od=%h want 1 %h",
                   c - 2, out_valid, out_data, inv8(w, 6));
        end
      end
      if (c >= 2 && c < 256) begin
        total++;
        if (occupancy !== 2'd3) begin
          bad++;
          $display("FAIL stream_occ cyc=%0d got=%0d want=3", c, occupancy);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure;
    int acc;
    logic [7:0] nxt;
    acc = 0; nxt = 8'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = nxt; out_ready = 1'b0;
      #1;
      if (in_ready) begin
        acc++;
        nxt++;
      end
      if (i >= 3) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h10) begin
          bad++;
          $display("FAIL bp_stable cyc=%0d ov=%b od=%h want 1 10",
                   i, out_valid, out_data);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (acc != 3 || occupancy !== 2'd3 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full acc=%0d occ=%0d ir=%b want 3 3 0",
               acc, occupancy, in_ready);
    end
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_block ir=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_passthru ir=%b want 1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k)) begin
        bad++;
        $display("FAIL bp_drain k=%0d ov=%b od=%h want 1 %h",
                 k, out_valid, out_data, 8'(8'h10 + k));
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL bp_empty ov=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'hE2;
    @(negedge clk);
    in_data = 8'hE3; flush = 1'b1;
    #1;
    total++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle occ=%0d ir=%b want 2 0", occupancy, in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_after occ=%0d ov=%b want 0 0", occupancy, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (out_valid) begin
        seen++;
        total++;
        if (out_data !== 8'h77) begin
          bad++;
          $display("FAIL flush_leak od=%h want 77", out_data);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL flush_count got=%0d want=1", seen);
    end
  endtask

  task automatic test_random;
    bit exp_ir;
    bit stalled;
    logic [7:0] prev_od;
    stalled = 0; prev_od = '0;
    q.delete();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      in_valid  = (c < 680) && ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(2) != 0) || (c >= 680);
      flush     = (c < 680) && ($urandom_range(24) == 0);
      #1;
      exp_ir = !flush && (q.size() < S || out_ready);
      total++;
      if (in_ready !== exp_ir || occupancy !== 2'(q.size())) begin
        bad++;
        $display("FAIL rand_hs cyc=%0d ir=%b occ=%0d want %b %0d",
                 c, in_ready, occupancy, exp_ir, q.size());
      end
      if (stalled) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== prev_od) begin
          bad++;
          $display("FAIL rand_stall cyc=%0d ov=%b od=%h want 1 %h",
                   c, out_valid, out_data, prev_od);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra cyc=%0d od=%h want none", c, out_data);
        end else begin
          if (out_data !== inv8(q[0], 6)) begin
            bad++;
            $display("FAIL rand_data cyc=%0d od=%h want %h",
                     c, out_data, inv8(q[0], 6));
          end
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && exp_ir) q.push_back(in_data);
      stalled = out_valid && !out_ready && !flush;
      prev_od = out_data;
    end
    total++;
    if (q.size() != 0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL rand_end left=%0d occ=%0d want 0 0", q.size(), occupancy);
    end
    idle(1);
  endtask

  task automatic test_sweep;
    int lat [5];
    logic [7:0] dat [5];
    int sn [5] = '{5, 6, 6, 1, 3};
    int ss [5] = '{3, 6, 1, 1, 2};
    logic [7:0] mk [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      lat[i] = -1; dat[i] = '0;
    end
    @(negedge clk);
    sw_valid = 1'b1; sw_data = 8'hC3;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1 sw_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (sov[i] && lat[i] < 0) begin
          lat[i] = c + 1;
          dat[i] = sod[i];
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      exp = inv8(8'hC3, sn[i]) & mk[i];
      total++;
      if (lat[i] != ss[i] || dat[i] !== exp) begin
        bad++;
        $display("FAIL sweep%0d lat=%0d od=%h want %0d %h",
                 i, lat[i], dat[i], ss[i], exp);
      end
    end
    total++;
    if (occ_a !== 0 || occ_b !== 0 || occ_c !== 0 || occ_d !== 0 ||
        occ_e !== 0 || !(sir[0] && sir[1] && sir[2] && sir[3] && sir[4])) begin
      bad++;
      $display("FAIL sweep_idle occ=%0d/%0d/%0d/%0d/%0d want all 0 ready 1",
               occ_a, occ_b, occ_c, occ_d, occ_e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_random;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_pipe.md
# inv_pipe

Parametrised, pipelined successor to the single-bit inverter chain. Carries a W-bit word through N inverter stages that are split into segments of K inverters, with a register after each segment, and a valid/ready handshake at both ends. It is the characterisation and flow test vehicle for timing-driven synthesis: depth, width and pipelining are all swept from parameters. Backpressure, flush and occupancy reporting let the bench check that the pipeline never drops or reorders data.

## Interface
- W, 8, data width in bits (W ≥ 1)
- N, 6, total inverter stages per bit (N ≥ 1)
- K, 2, inverters per pipeline segment (1 ≤ K ≤ N)
- S (localparam), ceil(N/K), number of pipeline registers
- OW (localparam), $clog2(S+1), occupancy width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word present
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  W  input word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  W  in_data inverted N times
- flush  in  1  synchronous clear of all in-flight words
- occupancy  out  OW  number of valid pipeline registers

## Operation
- Segment j (0..S-1) contains K inverters per bit. The last segment contains N-(S-1)·K inverters. Every segment feeds register j, which holds a data field and a valid bit v[j].
- Functional result: out_data = in_data ^ {W{N[0]}}. The word is unchanged for even N and bitwise inverted for odd N.
- Ready chain is combinational: r[S] = out_ready; r[j] = ~v[j] | r[j+1]; in_ready = r[0] & ~flush.
- When r[j] is high, register j loads on the edge: v[0] ← in_valid & in_ready; v[j] ← v[j-1] for j ≥ 1; data[j] ← segment j output. When r[j] is low, register j holds both valid and data.
- out_valid = v[S-1]. out_data = data[S-1].
- occupancy = popcount(v), updated every edge.
- Flush: all v[j] ← 0 on the next edge. The data fields are left unchanged. Flush has priority over accept, and no word is accepted in a flush cycle. A word presented to the output in the flush cycle counts as transferred only if out_ready was high in that same cycle.
- out_data is stable while out_valid=1 & out_ready=0.
- Words exit in acceptance order. No word is ever lost or duplicated.

## Timing
- Reset (rst_n=0, takes effect immediately without a clock edge): all v[j]=0, all data[j]=0. Resulting outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1 (while flush=0).
- Latency: a word accepted at edge t is presented with out_valid=1 after edge t+S-1, i.e. it is visible from cycle t+S-1 onward. This assumes out_ready stays high.
- Throughput: one word per cycle when out_ready is held high.
- Full: occupancy=S and out_ready=0 give in_ready=0. If out_ready rises, in_ready rises in the same cycle (combinational pass-through, no bubble).
- Empty: occupancy=0 gives in_ready=1 regardless of out_ready.
- Simultaneous exit and entry at full: occupancy stays S.
- Reset asserted mid-stream discards all in-flight words. There is no partial output after rst_n deasserts.
- Critical path: K inverters plus register setup. The in_ready path goes through S AND/OR levels.

## Structure
- Shared package inv_pkg holds:
  - function ceil_div(n, k)
  - localparam helpers for S and OW
  - typedef of the per-stage record {logic v; logic [W-1:0] d} as a parameterised struct, via a macro or an interface-sized packed type
- Sub-module inv_seg (parameters W, M):
  - a W-bit, M-deep generate chain of inverters
  - instantiates the library inverter cell under SYNTHESIS and the behavioural inverter otherwise
- inv_pipe itself:
  - instantiates S inv_seg blocks, with M = K for all but the last
  - contains the S-stage register array, ready chain, flush logic and popcount

## Test plan
- Reset, W=8/N=6/K=2 (S=3): pulse rst_n low with no clock -> out_valid=0, out_data=0x00, occupancy=0, in_ready=1.
- Single word 0xA5 accepted at edge t, out_ready=1 -> out_valid=1 from cycle t+2 with out_data=0xA5. Same test with N=5 -> out_data=0x5A.
- Stream 0x00..0xFF back-to-back, out_ready=1 -> 256 outputs on consecutive cycles, in order, each inverted per N parity. occupancy holds at 3 in steady state.
- Backpressure: in_valid=1, out_ready=0 for 6 cycles -> exactly 3 accepts, then in_ready=0, occupancy=3, out_data stable. Raise out_ready -> drains in order, and in_ready=1 in the same cycle.
- Flush with occupancy=2 -> next cycle occupancy=0, out_valid=0, in_ready=0 during the flush cycle, and the flushed words never appear at the output.
- Sweep K=1, K=N, N=1, W=1 -> latency equals ceil(N/K) in every case, and the data results are correct.
